// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width and the fetch controller state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StRedir = 2'd2,
    StFault = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Saturating imem wait counter; flags the last tolerated wait cycle.
module fetch_wait_cnt #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the MAX_WAIT-th consecutive waiting cycle.
  assign timeout_o = inc_i && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC holds, next-PC select and IF/ID flush/stall around a
// handshaked instruction memory, with deferred branch redirect and fetch timeout.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            hazard_i,
  input  logic            dmem_busy_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            imem_ack_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            stall_o,
  output logic            pcEnable_o,
  output logic            ifid_stall_o,
  output logic            ifid_flush_o,
  output logic            fault_o
);

  fetch_state_e    state_q, state_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            waiting, timeout;

  assign waiting = ((state_q == StFetch) || (state_q == StRedir)) && !imem_ack_i;

  fetch_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (!start_i || !waiting),
    .inc_i     (waiting),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d      = state_q;
    redir_d      = redir_q;
    tgt_d        = tgt_q;
    imem_req_o   = 1'b0;
    pc_next_o    = '0;
    stall_o      = 1'b0;
    pcEnable_o   = 1'b0;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    fault_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        imem_req_o = 1'b1;
        pc_next_o  = pc_plus4_i;
        if (!imem_ack_i) begin
          pcEnable_o   = 1'b1;
          ifid_flush_o = 1'b1;
          if (timeout) begin
            state_d = StFault;
          end else if (branch_taken_i && !hazard_i && !dmem_busy_i) begin
            tgt_d   = branch_target_i;
            redir_d = 1'b1;
            state_d = StRedir;
          end
        end else if (dmem_busy_i || hazard_i) begin
          stall_o      = 1'b1;
          ifid_stall_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_next_o    = branch_target_i;
          ifid_flush_o = 1'b1;
        end
      end
      StRedir: begin
        // Word returned here belongs to the fall-through path, so it is always squashed.
        imem_req_o   = 1'b1;
        ifid_flush_o = 1'b1;
        pc_next_o    = pc_plus4_i;
        if (imem_ack_i && redir_q) begin
          pc_next_o = tgt_q;
          redir_d   = 1'b0;
          state_d   = StFetch;
        end else begin
          pcEnable_o = 1'b1;
          if (timeout) state_d = StFault;
        end
      end
      StFault: begin
        fault_o      = 1'b1;
        pcEnable_o   = 1'b1;
        ifid_flush_o = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (!start_i) begin
      state_d = StIdle;
      redir_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      redir_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl against a behavioural fetch model.
module tb_fetch_ctrl;

  localparam int unsigned MaxWait = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        hazard_i = 1'b0;
  logic        dmem_busy_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] pc_plus4_i = '0;
  logic        imem_ack_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] pc_next_o;
  logic        stall_o, pcEnable_o, ifid_stall_o, ifid_flush_o, fault_o;

  fetch_ctrl #(
    .MAX_WAIT (MaxWait),
    .WAIT_W   (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .hazard_i        (hazard_i),
    .dmem_busy_i     (dmem_busy_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_plus4_i      (pc_plus4_i),
    .imem_ack_i      (imem_ack_i),
    .imem_req_o      (imem_req_o),
    .pc_next_o       (pc_next_o),
    .stall_o         (stall_o),
    .pcEnable_o      (pcEnable_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .fault_o         (fault_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model: running/faulted flags, a pending redirect and a run of waits.
  bit          m_run, m_fault, m_redir;
  logic [31:0] m_tgt;
  int unsigned m_waits;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic        e_req, e_stall, e_pcen, e_istall, e_iflush, e_fault;
    logic [31:0] e_pc;
    {e_req, e_stall, e_pcen, e_istall, e_iflush, e_fault} = '0;
    e_pc = pc_plus4_i;
    if (!rst_i || !m_run) begin
      e_pc = '0;
    end else if (m_fault) begin
      e_pc = '0; e_fault = 1; e_pcen = 1; e_iflush = 1;
    end else begin
      e_req = 1;
      if (!imem_ack_i) begin
        e_pcen = 1; e_iflush = 1;
      end else if (m_redir) begin
        e_iflush = 1; e_pc = m_tgt;
      end else if (dmem_busy_i || hazard_i) begin
        e_stall = 1; e_istall = 1;
      end else if (branch_taken_i) begin
        e_iflush = 1; e_pc = branch_target_i;
      end
    end
    check_eq("imem_req", 32'(imem_req_o), 32'(e_req));
    check_eq("pc_next", pc_next_o, e_pc);
    check_eq("stall", 32'(stall_o), 32'(e_stall));
    check_eq("pcEnable", 32'(pcEnable_o), 32'(e_pcen));
    check_eq("ifid_stall", 32'(ifid_stall_o), 32'(e_istall));
    check_eq("ifid_flush", 32'(ifid_flush_o), 32'(e_iflush));
    check_eq("fault", 32'(fault_o), 32'(e_fault));
  endtask

  task automatic model_edge();
    if (!rst_i || !start_i) begin
      m_run = 0; m_fault = 0; m_redir = 0; m_waits = 0;
      if (!rst_i) m_tgt = '0;
    end else if (!m_run) begin
      m_run = 1; m_waits = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (imem_ack_i) begin
      m_waits = 0; m_redir = 0;
    end else if (m_waits + 1 >= MaxWait) begin
      m_fault = 1;
    end else begin
      m_waits++;
      if (!m_redir && branch_taken_i && !hazard_i && !dmem_busy_i) begin
        m_redir = 1; m_tgt = branch_target_i;
      end
    end
  endtask

  task automatic do_cycle(input logic rst, input logic start, input logic ack, input logic haz,
                          input logic dmem, input logic taken, input logic [31:0] tgt,
                          input logic [31:0] pc4);
    @(negedge clk);
    rst_i = rst; start_i = start; imem_ack_i = ack; hazard_i = haz;
    dmem_busy_i = dmem; branch_taken_i = taken; branch_target_i = tgt; pc_plus4_i = pc4;
    #1;
    check_outputs();
    model_edge();
  endtask

  initial begin
    m_run = 0; m_fault = 0; m_redir = 0; m_tgt = '0; m_waits = 0;
    do_cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h4);          // IDLE -> FETCH
    do_cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h4);
    do_cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h8);
    do_cycle(1, 1, 1, 1, 0, 1, 32'h200, 32'hc);         // hazard beats branch
    do_cycle(1, 1, 0, 0, 0, 1, 32'h100, 32'h10);        // branch during wait
    do_cycle(1, 1, 0, 0, 0, 1, 32'h300, 32'h10);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h10);
    do_cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h10);
    check_eq("redir_target", pc_next_o, 32'h100);
    do_cycle(1, 1, 1, 1, 1, 0, 32'h0, 32'h104);         // dmem over hazard
    check_eq("dmem_no_flush", 32'(ifid_flush_o), 32'h0);
    for (int i = 0; i < int'(MaxWait); i++) do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h108);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h108);
    check_eq("fault_after_max", 32'(fault_o), 32'h1);
    do_cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h108);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h108);
    check_eq("fault_cleared", 32'(fault_o), 32'h0);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h4);
    do_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h4);           // reset mid-fetch
    check_eq("reset_req", 32'(imem_req_o), 32'h0);
    do_cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h4);
    do_cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h8);
    check_eq("req_after_start", 32'(imem_req_o), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      int unsigned ack_pct;
      ack_pct = (i % 1000 < 300) ? 5 : 60;
      do_cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) != 0),
               ($urandom_range(0, 99) < ack_pct), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
               $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
